// File: rtl/bin2bcd_fixed_seq.sv
// Sequential signed fixed-point to BCD converter (double dabble, one bit per clock).
// Converts |acc_int|*10^FRAC_DIGITS + frac and reports sign, overflow and fraction-range flags.
module bin2bcd_fixed_seq #(
  parameter int INT_W       = 8,
  parameter int FRAC_W      = 7,
  parameter int FRAC_DIGITS = 2,
  parameter int INT_DIGITS  = 3,
  localparam int NDIG       = INT_DIGITS + FRAC_DIGITS,
  localparam int MAG_W      = INT_W + 4*FRAC_DIGITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INT_W-1:0]  acc_int,
  input  logic [FRAC_W-1:0] frac,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] bcd,
  output logic              sign,
  output logic              ovf,
  output logic              frac_err
);

  function automatic int unsigned pow10(input int n);
    int unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam int unsigned     FRAC_SCALE = pow10(FRAC_DIGITS);
  localparam logic [FRAC_W-1:0] FRAC_MAX = FRAC_W'(FRAC_SCALE - 1);
  localparam int              CNT_W      = $clog2(MAG_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t              state_reg, state_next;
  logic [INT_W-1:0]    int_reg;
  logic [FRAC_W-1:0]   frac_reg;
  logic [MAG_W-1:0]    mag_reg;
  logic [4*NDIG-1:0]   bcd_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                sign_reg, ovf_reg, frac_err_reg;

  logic                frac_over;
  logic [INT_W:0]      int_ext, abs_int;
  logic [MAG_W-1:0]    mag_load;
  logic [4*NDIG-1:0]   bcd_adj;

  assign frac_over = 32'(frac) >= FRAC_SCALE;

  // One extra bit so the most negative integer has an exact magnitude
  assign int_ext  = {int_reg[INT_W-1], int_reg};
  assign abs_int  = int_ext[INT_W] ? (~int_ext + (INT_W+1)'(1)) : int_ext;
  assign mag_load = MAG_W'(abs_int) * MAG_W'(FRAC_SCALE) + MAG_W'(frac_reg);

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = LOAD;
      end
      LOAD: state_next = SHIFT;
      SHIFT: begin
        if (cnt_reg == CNT_W'(1)) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      int_reg      <= '0;
      frac_reg     <= '0;
      mag_reg      <= '0;
      bcd_reg      <= '0;
      cnt_reg      <= '0;
      sign_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      frac_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            int_reg      <= acc_int;
            frac_reg     <= frac_over ? FRAC_MAX : frac;
            sign_reg     <= acc_int[INT_W-1];
            frac_err_reg <= frac_over;
            ovf_reg      <= 1'b0;
          end
        end
        LOAD: begin
          mag_reg <= mag_load;
          bcd_reg <= '0;
          cnt_reg <= CNT_W'(MAG_W);
        end
        SHIFT: begin
          // A carry out of the top digit means the value needs more digits than we keep
          bcd_reg <= {bcd_adj[4*NDIG-2:0], mag_reg[MAG_W-1]};
          mag_reg <= mag_reg << 1;
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (bcd_adj[4*NDIG-1]) ovf_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bcd      = bcd_reg;
  assign sign     = sign_reg;
  assign ovf      = ovf_reg;
  assign frac_err = frac_err_reg;

endmodule

// File: tb/tb_bin2bcd_fixed_seq.sv
// Testbench for bin2bcd_fixed_seq: vector table, random vs decimal model, hold/reset/streaming sequences.
// A second instance with two integer digits exercises the overflow path.
module tb_bin2bcd_fixed_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  acc_int;
  logic [6:0]  frac;
  logic [19:0] bcd;
  logic        sign, ovf, frac_err;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_acc_int;
  logic [6:0]  b_frac;
  logic [15:0] b_bcd;
  logic        b_sign, b_ovf, b_frac_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bin2bcd_fixed_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .acc_int(acc_int), .frac(frac), .out_valid(out_valid), .out_ready(out_ready),
    .bcd(bcd), .sign(sign), .ovf(ovf), .frac_err(frac_err)
  );

  bin2bcd_fixed_seq #(.INT_DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .acc_int(b_acc_int), .frac(b_frac), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .bcd(b_bcd), .sign(b_sign), .ovf(b_ovf), .frac_err(b_frac_err)
  );

  typedef struct {
    int          a;
    int          f;
    logic [31:0] bcd;
    logic        s;
    logic        o;
    logic        e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no response within cycle budget", name);
  endtask

  // Decimal reference: value = |a|*100 + min(f,99), digits by division
  function automatic void model(input int a, input int f, input int idig,
                                output logic [31:0] b, output logic s, output logic o, output logic e);
    int m, v;
    e = (f >= 100);
    m = (a < 0) ? -a : a;
    s = (a < 0);
    o = (m >= 10**idig);
    v = m * 100 + (e ? 99 : f);
    b = '0;
    for (int d = 0; d < idig + 2; d++) b[4*d +: 4] = 4'((v / (10**d)) % 10);
  endfunction

  task automatic set_in(input bit sel, input logic v, input int a, input int f);
    if (sel) begin b_in_valid = v; b_acc_int = 8'(a); b_frac = 7'(f); end
    else     begin in_valid = v;   acc_int = 8'(a);   frac = 7'(f);   end
  endtask

  task automatic do_conv(input bit sel, input int a, input int f, output int lat,
                         output logic [31:0] b, output logic s, output logic o, output logic e);
    int n;
    set_in(sel, 1'b1, a, f);
    n = 0;
    while (!(sel ? b_in_ready : in_ready) && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) timeout("accept");
    @(posedge clk); #1;
    set_in(sel, 1'b0, a, f);
    lat = 1;
    while (!(sel ? b_out_valid : out_valid) && lat < 100) begin @(posedge clk); #1; lat++; end
    if (lat >= 100) timeout("out_valid");
    b = sel ? {16'b0, b_bcd} : {12'b0, bcd};
    s = sel ? b_sign : sign;
    o = sel ? b_ovf : ovf;
    e = sel ? b_frac_err : frac_err;
    if (sel) b_out_ready = 1'b1; else out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    out_ready   = 1'b0;
    $display("conv dut%0d a=%0d f=%0d -> bcd=%h sign=%0d ovf=%0d ferr=%0d lat=%0d",
             sel ? 2 : 1, a, f, b, s, o, e, lat);
  endtask

  task automatic run_vec(input bit sel, input vec_t v);
    int lat;
    logic [31:0] b;
    logic s, o, e;
    do_conv(sel, v.a, v.f, lat, b, s, o, e);
    check("bcd", b, v.bcd);
    check("sign", 32'(s), 32'(v.s));
    check("ovf", 32'(o), 32'(v.o));
    check("frac_err", 32'(e), 32'(v.e));
    check("latency", lat, 18);
  endtask

  vec_t tv1[9];
  vec_t tv2[4];

  initial begin
    int a, f, lat, idx, got, last;
    logic [31:0] b, mb, hb;
    logic s, o, e, ms, mo, me;
    int bb_a[5];
    int bb_f[5];
    vec_t exp_q[$];
    vec_t ev;
    bit acc;

    tv1[0] = '{-5, 25, 32'h00525, 1'b1, 1'b0, 1'b0};
    tv1[1] = '{-128, 0, 32'h12800, 1'b1, 1'b0, 1'b0};
    tv1[2] = '{127, 99, 32'h12799, 1'b0, 1'b0, 1'b0};
    tv1[3] = '{3, 100, 32'h00399, 1'b0, 1'b0, 1'b1};
    tv1[4] = '{42, 0, 32'h04200, 1'b0, 1'b0, 1'b0};
    tv1[5] = '{0, 0, 32'h00000, 1'b0, 1'b0, 1'b0};
    tv1[6] = '{0, 50, 32'h00050, 1'b0, 1'b0, 1'b0};
    tv1[7] = '{-1, 99, 32'h00199, 1'b1, 1'b0, 1'b0};
    tv1[8] = '{100, 127, 32'h10099, 1'b0, 1'b0, 1'b1};
    tv2[0] = '{127, 5, 32'h2705, 1'b0, 1'b1, 1'b0};
    tv2[1] = '{99, 99, 32'h9999, 1'b0, 1'b0, 1'b0};
    tv2[2] = '{-100, 0, 32'h0000, 1'b1, 1'b1, 1'b0};
    tv2[3] = '{-99, 100, 32'h9999, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; acc_int = '0; frac = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_acc_int = '0; b_frac = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_bcd", 32'(bcd), 0);
    check("rst_flags", {29'b0, sign, ovf, frac_err}, 0);
    check("rst_in_ready2", 32'(b_in_ready), 1);

    foreach (tv1[i]) run_vec(1'b0, tv1[i]);
    foreach (tv2[i]) run_vec(1'b1, tv2[i]);

    for (int i = 0; i < 40; i++) begin
      bit sel;
      sel = (i >= 30);
      a = int'($urandom_range(255)) - 128;
      f = int'($urandom_range(127));
      do_conv(sel, a, f, lat, b, s, o, e);
      model(a, f, sel ? 2 : 3, mb, ms, mo, me);
      check("rand_bcd", b, mb);
      check("rand_sign", 32'(s), 32'(ms));
      check("rand_ovf", 32'(o), 32'(mo));
      check("rand_frac_err", 32'(e), 32'(me));
    end

    // Consumer stalls in DONE while the producer keeps offering new data
    set_in(1'b0, 1'b1, 7, 7);
    @(posedge clk); #1;
    set_in(1'b0, 1'b1, -9, 9);
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (lat >= 100) timeout("hold_out_valid");
    hb = {12'b0, bcd};
    check("hold_bcd", hb, 32'h00707);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 1);
      check("hold_stable", {12'b0, bcd}, hb);
      check("hold_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_in_ready", 32'(in_ready), 1);
    check("release_valid", 32'(out_valid), 0);
    check("release_bcd_kept", {12'b0, bcd}, 32'h00707);
    $display("hold sequence done, bcd=%h", bcd);

    // Reset in the middle of SHIFT discards the conversion
    set_in(1'b0, 1'b1, -128, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("midshift_bcd_nonzero", 32'(bcd != '0), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_bcd", 32'(bcd), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_sign", 32'(sign), 0);
    rst = 1'b0;
    $display("reset mid-shift applied");
    run_vec(1'b0, tv1[4]);

    // Streaming with in_valid and out_ready held high
    bb_a = '{12, 0, -77, 127, -1};
    bb_f = '{34, 0, 3, 99, 1};
    idx = 0; got = 0; last = -1;
    out_ready = 1'b1;
    set_in(1'b0, 1'b1, bb_a[0], bb_f[0]);
    for (int c = 0; c < 300 && got < 5; c++) begin
      acc = in_ready && in_valid;
      if (out_valid) begin
        if (exp_q.size() > 0) begin
          ev = exp_q.pop_front();
          check("b2b_bcd", {12'b0, bcd}, ev.bcd);
          check("b2b_sign", 32'(sign), 32'(ev.s));
          check("b2b_frac_err", 32'(frac_err), 32'(ev.e));
          $display("b2b result a=%0d f=%0d bcd=%h sign=%0d", ev.a, ev.f, bcd, sign);
        end else begin
          timeout("b2b_unexpected_result");
        end
        got++;
      end
      if (acc) begin
        model(bb_a[idx], bb_f[idx], 3, mb, ms, mo, me);
        exp_q.push_back('{bb_a[idx], bb_f[idx], mb, ms, mo, me});
        if (last >= 0) check("b2b_interval", c - last, 19);
        last = c;
      end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 5) set_in(1'b0, 1'b1, bb_a[idx], bb_f[idx]);
        else         in_valid = 1'b0;
      end
    end
    if (got < 5) timeout("b2b_results");
    out_ready = 1'b0;
    in_valid  = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
